// File: rtl/dq_clear_gen_pkg.sv
// Shared defaults and pointer arithmetic for the dispatch-queue clear generator.
package dq_clear_gen_pkg;

  localparam int DEF_DEPTH         = 30;
  localparam int DEF_SRC_NUM       = 6;
  localparam int DEF_CLEARPORT_NUM = 4;
  localparam int DEF_FIFO_DEPTH    = 12;

  // Circular advance; n never exceeds depth, so one subtraction suffices.
  function automatic int wrap_add(input int ptr, input int n, input int depth);
    return (ptr + n >= depth) ? (ptr + n - depth) : (ptr + n);
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dq_clear_gen_if.sv
// Completion-source and clear-port bundle between writeback sources and the clear generator.
interface dq_clear_gen_if
  import dq_clear_gen_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int SRC_NUM       = DEF_SRC_NUM,
  parameter int CLEARPORT_NUM = DEF_CLEARPORT_NUM
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [SRC_NUM-1:0]       i_src_vld;
  logic [IDX_W-1:0]         i_src_dqIdx [SRC_NUM];
  logic                     o_src_rdy;
  logic                     i_flush;
  logic [CLEARPORT_NUM-1:0] o_clear_vld;
  logic [IDX_W-1:0]         o_clear_dqIdx [CLEARPORT_NUM];

  modport master (
    output i_src_vld, i_src_dqIdx, i_flush,
    input  o_src_rdy, o_clear_vld, o_clear_dqIdx
  );

  modport slave (
    input  i_src_vld, i_src_dqIdx, i_flush,
    output o_src_rdy, o_clear_vld, o_clear_dqIdx
  );
endinterface

// File: rtl/dq_clear_gen.sv
// Buffers completion events from many writeback sources in a circular FIFO and
// drains them oldest-first onto a narrower clear port of a dispatch data queue.
module dq_clear_gen
  import dq_clear_gen_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int SRC_NUM       = DEF_SRC_NUM,
  parameter int CLEARPORT_NUM = DEF_CLEARPORT_NUM,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input logic          clk,
  input logic          rst,
  dq_clear_gen_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENQ_W = $clog2(SRC_NUM + 1);

  logic [IDX_W-1:0] buffer [FIFO_DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  logic             rdy;
  logic             accept;
  logic [ENQ_W-1:0] enq_num;
  logic [IDX_W-1:0] comp_idx [SRC_NUM];
  int               drain_num;

  // Ready uses the pre-drain count so acceptance never waits on the drain path.
  assign rdy           = (FIFO_DEPTH - int'(count)) >= SRC_NUM;
  assign accept        = rdy && !bus.i_flush;
  assign bus.o_src_rdy = rdy;

  always_comb begin
    enq_num = '0;
    for (int k = 0; k < SRC_NUM; k++) comp_idx[k] = '0;
    for (int s = 0; s < SRC_NUM; s++) begin
      if (bus.i_src_vld[s]) begin
        comp_idx[enq_num] = bus.i_src_dqIdx[s];
        enq_num           = enq_num + ENQ_W'(1);
      end
    end
  end

  always_comb begin
    drain_num       = min_int(int'(count), CLEARPORT_NUM);
    bus.o_clear_vld = '0;
    for (int k = 0; k < CLEARPORT_NUM; k++) begin
      bus.o_clear_vld[k]   = (k < drain_num);
      bus.o_clear_dqIdx[k] = buffer[PTR_W'(wrap_add(int'(head_ptr), k, FIFO_DEPTH))];
    end
  end

  // Flush still retires the entries shown on the clear port this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) buffer[i] <= '0;
    end else if (bus.i_flush) begin
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < SRC_NUM; k++) begin
          if (k < int'(enq_num))
            buffer[PTR_W'(wrap_add(int'(tail_ptr), k, FIFO_DEPTH))] <= comp_idx[k];
        end
        tail_ptr <= PTR_W'(wrap_add(int'(tail_ptr), int'(enq_num), FIFO_DEPTH));
      end
      head_ptr <= PTR_W'(wrap_add(int'(head_ptr), drain_num, FIFO_DEPTH));
      count    <= CNT_W'(int'(count) + (accept ? int'(enq_num) : 0) - drain_num);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (int'(count) <= FIFO_DEPTH)
        else $error("dq_clear_gen: pending count exceeds storage");
      assert (rdy || bus.i_flush || (bus.i_src_vld == '0))
        else $warning("dq_clear_gen: source events ignored while not ready");
      for (int i = 0; i < SRC_NUM; i++) begin
        for (int j = i + 1; j < SRC_NUM; j++) begin
          assert (!(bus.i_src_vld[i] && bus.i_src_vld[j] &&
                    (bus.i_src_dqIdx[i] == bus.i_src_dqIdx[j])))
            else $error("dq_clear_gen: duplicate slot index among same-cycle sources");
        end
      end
    end
  end

endmodule

// File: tb/tb_dq_clear_gen.sv
// Directed and randomized bench for dq_clear_gen against a queue-based model of pending clears.
module tb_dq_clear_gen;
  localparam int DEPTH         = 30;
  localparam int SRC_NUM       = 6;
  localparam int CLEARPORT_NUM = 4;
  localparam int FIFO_DEPTH    = 12;
  localparam int IDX_W         = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   q[$];

  dq_clear_gen_if #(.DEPTH(DEPTH), .SRC_NUM(SRC_NUM), .CLEARPORT_NUM(CLEARPORT_NUM)) bus ();

  dq_clear_gen #(
    .DEPTH(DEPTH), .SRC_NUM(SRC_NUM), .CLEARPORT_NUM(CLEARPORT_NUM), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic bit model_rdy();
    return (FIFO_DEPTH - q.size()) >= SRC_NUM;
  endfunction

  task automatic check_outputs(input string tag);
    int nd;
    logic [CLEARPORT_NUM-1:0] exp_vld;
    nd = (q.size() < CLEARPORT_NUM) ? q.size() : CLEARPORT_NUM;
    exp_vld = '0;
    for (int k = 0; k < nd; k++) exp_vld[k] = 1'b1;
    check({tag, ".rdy"}, 32'(bus.o_src_rdy), 32'(model_rdy()));
    check({tag, ".vld"}, 32'(bus.o_clear_vld), 32'(exp_vld));
    for (int k = 0; k < nd; k++)
      check($sformatf("%s.idx%0d", tag, k), 32'(bus.o_clear_dqIdx[k]), 32'(q[k]));
    check({tag, ".count"}, 32'(dut.count), 32'(q.size()));
  endtask

  // One clock: present inputs, advance the model across the edge, then compare.
  task automatic step(input string tag, input logic [SRC_NUM-1:0] vld,
                      input int idx[SRC_NUM], input logic flush);
    bit rdy_m;
    int nd;
    bus.i_src_vld = vld;
    for (int s = 0; s < SRC_NUM; s++) bus.i_src_dqIdx[s] = IDX_W'(idx[s]);
    bus.i_flush = flush;
    rdy_m = model_rdy();
    nd = (q.size() < CLEARPORT_NUM) ? q.size() : CLEARPORT_NUM;
    repeat (nd) void'(q.pop_front());
    if (flush) q.delete();
    else if (rdy_m)
      for (int s = 0; s < SRC_NUM; s++) if (vld[s]) q.push_back(idx[s]);
    @(posedge clk);
    #1;
    bus.i_src_vld = '0;
    bus.i_flush   = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    int z[SRC_NUM];
    for (int s = 0; s < SRC_NUM; s++) z[s] = 0;
    repeat (n) step(tag, '0, z, 1'b0);
  endtask

  task automatic rand_step();
    int idx[SRC_NUM];
    bit used[DEPTH];
    logic [SRC_NUM-1:0] vld;
    int v;
    for (int i = 0; i < DEPTH; i++) used[i] = 1'b0;
    for (int s = 0; s < SRC_NUM; s++) begin
      v = $urandom_range(DEPTH - 1);
      while (used[v]) v = (v + 1) % DEPTH;
      used[v] = 1'b1;
      idx[s]  = v;
    end
    vld = model_rdy() ? SRC_NUM'($urandom) : '0;
    step("rand", vld, idx, ($urandom_range(19) == 0));
  endtask

  initial begin
    int  b_idx[SRC_NUM];
    bit  saw_not_ready;
    bit  taken;
    bus.i_src_vld = '0;
    bus.i_flush   = 1'b0;
    for (int s = 0; s < SRC_NUM; s++) bus.i_src_dqIdx[s] = '0;

    // Reset and idle
    #1 rst = 1'b1;
    #2;
    check("rst.async_vld", 32'(bus.o_clear_vld), 32'(0));
    check("rst.async_rdy", 32'(bus.o_src_rdy), 32'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst.count", 32'(dut.count), 32'(0));
    for (int k = 0; k < CLEARPORT_NUM; k++)
      check($sformatf("rst.idx%0d", k), 32'(bus.o_clear_dqIdx[k]), 32'(0));
    idle("idle", 2);

    // Single event from source 3
    step("single", 6'b001000, '{0, 0, 0, 17, 0, 0}, 1'b0);
    check("single.vld_const", 32'(bus.o_clear_vld), 32'(4'b0001));
    check("single.idx_const", 32'(bus.o_clear_dqIdx[0]), 32'(17));
    idle("single_after", 1);
    check("single.vld_gone", 32'(bus.o_clear_vld), 32'(0));

    // Burst wider than the clear port
    step("burst", 6'b111111, '{0, 1, 2, 3, 4, 5}, 1'b0);
    check("burst.vld1", 32'(bus.o_clear_vld), 32'(4'b1111));
    check("burst.idx3", 32'(bus.o_clear_dqIdx[3]), 32'(3));
    idle("burst2", 1);
    check("burst.vld2", 32'(bus.o_clear_vld), 32'(4'b0011));
    check("burst.idx4", 32'(bus.o_clear_dqIdx[0]), 32'(4));
    check("burst.idx5", 32'(bus.o_clear_dqIdx[1]), 32'(5));
    idle("burst3", 1);

    // Backpressure: re-present each full batch until accepted; drain across the wrap
    saw_not_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < SRC_NUM; s++) b_idx[s] = b * SRC_NUM + s;
      taken = 1'b0;
      for (int t = 0; t < 4 && !taken; t++) begin
        taken = model_rdy();
        if (!taken) saw_not_ready = 1'b1;
        step("bp", 6'b111111, b_idx, 1'b0);
      end
      if (!taken) check("bp.accept_timeout", 32'(0), 32'(1));
    end
    check("bp.rdy_dropped", 32'(saw_not_ready), 32'(1));
    idle("bp_drain", 6);
    check("bp.empty", 32'(dut.count), 32'(0));

    // Asynchronous reset with entries pending
    step("arst_fill", 6'b111111, '{10, 11, 12, 13, 14, 15}, 1'b0);
    #3 rst = 1'b1;
    #1;
    q.delete();
    check("arst.vld", 32'(bus.o_clear_vld), 32'(0));
    check("arst.rdy", 32'(bus.o_src_rdy), 32'(1));
    check("arst.count", 32'(dut.count), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    idle("arst_idle", 1);

    // Flush with five pending and two new events
    step("flush_fill", 6'b011111, '{20, 21, 22, 23, 24, 0}, 1'b0);
    check("flush.pre_vld", 32'(bus.o_clear_vld), 32'(4'b1111));
    check("flush.pre_idx0", 32'(bus.o_clear_dqIdx[0]), 32'(20));
    step("flush", 6'b000011, '{7, 8, 0, 0, 0, 0}, 1'b1);
    check("flush.vld", 32'(bus.o_clear_vld), 32'(0));
    check("flush.count", 32'(dut.count), 32'(0));
    idle("flush_after", 2);

    // Randomized traffic with occasional flushes
    repeat (400) rand_step();
    idle("final_drain", 4);
    check("final.count", 32'(dut.count), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
